uart_tx_serializer: RTL

Frame serializer for the serial transmit path. It sits directly downstream of the clock-divider stage running in pulse mode and consumes that stage's one-cycle `tick` as its baud-rate enable. It accepts a parallel word over a valid/ready handshake and shifts it out LSB-first as an asynchronous serial frame: start bit, data bits, optional parity, stop bit(s).

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_tx_serializer.sv | 139 +++++++++++++
 2 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
// Parity support is selected by the UART_TX_PARITY_EN macro.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ARMED,
      START,
      DATA,
      PARITY,
      STOP
   } uart_tx_state_t;

   localparam logic UART_IDLE_LEVEL = 1'b1;

`ifdef UART_TX_PARITY_EN
   localparam bit PARITY_EN = 1'b1;
`else
   localparam bit PARITY_EN = 1'b0;
`endif

   // Tick periods from the start bit to the end of the last stop bit.
   function automatic int frame_ticks(input int data_bits, input int stop_bits,
                                      input bit parity_en);
      return 1 + data_bits + (parity_en ? 1 : 0) + stop_bits;
   endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Tick-paced UART frame serializer: start, LSB-first data, optional even parity, stop bit(s).
// Defining UART_TX_PARITY_EN compiles in the PARITY state and parity bit.
module uart_tx_serializer
   import uart_pkg::*;
#(
   parameter int DATA_BITS = 8,
   parameter int STOP_BITS = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 tick,
   input  logic [DATA_BITS-1:0] data,
   input  logic                 valid,
   output logic                 ready,
   output logic                 tx,
   output logic                 busy
);

   localparam int IDX_W = $clog2(DATA_BITS);
   localparam int CNT_W = $clog2(STOP_BITS + 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STOP_BITS - 1);

   uart_tx_state_t       state, state_nxt;
   logic [IDX_W-1:0]     idx, idx_nxt;
   logic [CNT_W-1:0]     cnt, cnt_nxt;
   logic                 tx_q, tx_nxt;
   logic [DATA_BITS-1:0] shreg;
   logic                 load, shift;
`ifdef UART_TX_PARITY_EN
   logic                 par_q;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         idx   <= '0;
         cnt   <= '0;
         tx_q  <= UART_IDLE_LEVEL;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
         cnt   <= cnt_nxt;
         tx_q  <= tx_nxt;
      end
   end

   // Payload registers carry no reset; they are always loaded before use.
   always_ff @(posedge clk) begin
      if (load) begin
         shreg <= data;
      end else if (shift) begin
         shreg <= shreg >> 1;
      end
   end

`ifdef UART_TX_PARITY_EN
   always_ff @(posedge clk) begin
      if (load) begin
         par_q <= ^data;
      end
   end
`endif

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      cnt_nxt   = cnt;
      tx_nxt    = tx_q;
      load      = 1'b0;
      shift     = 1'b0;
      unique case (state)
         IDLE: begin
            if (valid) begin
               state_nxt = ARMED;
               load      = 1'b1;
            end
         end
         ARMED: begin
            if (tick) begin
               state_nxt = START;
               tx_nxt    = 1'b0;
            end
         end
         START: begin
            if (tick) begin
               state_nxt = DATA;
               tx_nxt    = shreg[0];
               shift     = 1'b1;
               idx_nxt   = '0;
            end
         end
         DATA: begin
            if (tick) begin
               if (idx != IDX_LAST) begin
                  tx_nxt  = shreg[0];
                  shift   = 1'b1;
                  idx_nxt = idx + IDX_W'(1);
               end else begin
`ifdef UART_TX_PARITY_EN
                  state_nxt = PARITY;
                  tx_nxt    = par_q;
`else
                  state_nxt = STOP;
                  tx_nxt    = UART_IDLE_LEVEL;
                  cnt_nxt   = '0;
`endif
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (tick) begin
               state_nxt = STOP;
               tx_nxt    = UART_IDLE_LEVEL;
               cnt_nxt   = '0;
            end
         end
`endif
         STOP: begin
            if (tick) begin
               if (cnt != CNT_LAST) begin
                  cnt_nxt = cnt + CNT_W'(1);
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      ready = (state == IDLE);
      busy  = (state != IDLE);
      tx    = tx_q;
   end

endmodule
